// File: rtl/fetch_unit.sv
// Instruction fetch: issues PC-addressed memory requests and feeds a fetch/decode register with a one-entry skid buffer.
// Latency: the request launches combinationally from PcIn; the instruction is presented on the edge after MemAck.
// Backpressure: Stall holds the output register; one extra response parks in the skid, and no request launches while it is full.
module fetch_unit #(
  parameter int n   = 32,
  parameter int INC = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [n-1:0] PcIn,
  output logic [n-1:0] PcOut,
  output logic         PcEnable,
  output logic         MemReq,
  output logic [n-1:0] MemAddr,
  input  logic         MemAck,
  input  logic [31:0]  MemData,
  input  logic         Stall,
  input  logic         BranchTaken,
  input  logic [n-1:0] BranchTarget,
  output logic         InstrValid,
  output logic [31:0]  Instr,
  output logic [n-1:0] InstrPc
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  localparam logic [n-1:0] INC_V = n'(INC);

  state_t       state_q;
  logic         req_q;          // request outstanding (MemReq already high)
  logic [n-1:0] addr_q;         // address of the outstanding request
  logic         vld_q;
  logic [31:0]  instr_q;
  logic [n-1:0] ipc_q;
  logic         skid_vld_q;
  logic [31:0]  skid_instr_q;
  logic [n-1:0] skid_pc_q;

  logic         launch_d;
  logic         req_act_d;
  logic [n-1:0] req_addr_d;
  logic         accept_d;
  logic         consume_d;
  logic         out_free_d;

  // Request launch and response qualification. A launch is suppressed during a
  // redirect because PcIn is about to be replaced and its data would be discarded.
  always_comb begin
    launch_d   = Reset && (state_q == FETCH) && !req_q && !skid_vld_q && !BranchTaken;
    req_act_d  = req_q || launch_d;
    req_addr_d = launch_d ? PcIn : addr_q;
    accept_d   = req_act_d && MemAck && (state_q == FETCH) && !BranchTaken;
    consume_d  = vld_q && !Stall;
    out_free_d = !vld_q || !Stall;
  end

  // PC register control: redirect beats accept; otherwise hold.
  always_comb begin
    PcEnable = 1'b1;
    PcOut    = '0;
    if (Reset) begin
      if (BranchTaken) begin
        PcEnable = 1'b0;
        PcOut    = BranchTarget;
      end else if (accept_d) begin
        PcEnable = 1'b0;
        PcOut    = req_addr_d + INC_V;   // wraps modulo 2^n
      end
    end
  end

  assign MemReq     = req_act_d;
  assign MemAddr    = req_addr_d;
  assign InstrValid = vld_q;
  assign Instr      = instr_q;
  assign InstrPc    = ipc_q;

  // FSM and outstanding-request tracking; an ack with nothing outstanding is ignored.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      if (launch_d) addr_q <= PcIn;
      req_q <= req_act_d && !MemAck;
      case (state_q)
        IDLE:    state_q <= FETCH;
        FETCH:   if (BranchTaken && req_q && !MemAck) state_q <= DROP;
        DROP:    if (MemAck) state_q <= FETCH;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output register and skid buffer; a redirect flushes both.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      vld_q        <= 1'b0;
      instr_q      <= '0;
      ipc_q        <= '0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else if (BranchTaken) begin
      vld_q      <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      if (consume_d) begin
        if (skid_vld_q) begin
          instr_q    <= skid_instr_q;
          ipc_q      <= skid_pc_q;
          skid_vld_q <= 1'b0;
        end else begin
          vld_q <= 1'b0;
        end
      end
      // The skid is never full here: no request can be outstanding while it is.
      if (accept_d) begin
        if (out_free_d) begin
          vld_q   <= 1'b1;
          instr_q <= MemData;
          ipc_q   <= req_addr_d;
        end else begin
          skid_vld_q   <= 1'b1;
          skid_instr_q <= MemData;
          skid_pc_q    <= req_addr_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bench-owned PC register and latency-programmable memory.
// Expected (pc, word) pairs are queued when the memory acks and popped on consume.
// Directed phases: reset, zero-wait stream, wait states, stall/skid, redirect, wrap, reset mid-request.
module tb_fetch_unit;

  localparam logic [31:0] INC = 32'd4;

  logic        Clk;
  logic        Reset;
  logic [31:0] PcIn;
  logic [31:0] PcOut;
  logic        PcEnable;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          lat;
  int          wcnt;
  logic        dropping;
  logic        force_ack;
  logic [31:0] nxt_pc;
  logic [31:0] hold_addr;
  int          pulses;

  fetch_unit #(.n(32), .INC(4)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PcIn         (PcIn),
    .PcOut        (PcOut),
    .PcEnable     (PcEnable),
    .MemReq       (MemReq),
    .MemAddr      (MemAddr),
    .MemAck       (MemAck),
    .MemData      (MemData),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .InstrValid   (InstrValid),
    .Instr        (Instr),
    .InstrPc      (InstrPc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle of memory/decode behaviour, evaluated after inputs have been set.
  task automatic respond();
    exp_t e;
    #1;
    MemAck  = 1'b0;
    MemData = '0;
    if (InstrValid && !Stall) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_instr", 32'(InstrValid), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("instr", Instr, e.dat);
        check_eq("instr_pc", InstrPc, e.pc);
      end
    end
    if (force_ack) begin
      MemAck  = 1'b1;
      MemData = 32'hBAD0_BAD0;
    end else if (MemReq && Reset) begin
      if (!dropping) check_eq("mem_addr", MemAddr, nxt_pc);
      if (wcnt >= lat) begin
        MemAck  = 1'b1;
        MemData = memf(MemAddr);
        wcnt    = 0;
      end else begin
        wcnt++;
      end
    end
    #1;
    if (Reset && BranchTaken) begin
      check_eq("br_pc_en", 32'(PcEnable), 32'd0);
      check_eq("br_pc_out", PcOut, BranchTarget);
      dropping = MemReq && !MemAck;
      sb.delete();
      nxt_pc = BranchTarget;
    end else if (MemAck && !force_ack) begin
      if (dropping) begin
        check_eq("drop_pc_en", 32'(PcEnable), 32'd1);
        dropping = 1'b0;
      end else begin
        check_eq("acc_pc_en", 32'(PcEnable), 32'd0);
        check_eq("acc_pc_out", PcOut, nxt_pc + INC);
        e.pc  = nxt_pc;
        e.dat = memf(nxt_pc);
        sb.push_back(e);
        nxt_pc = nxt_pc + INC;
      end
    end else if (Reset) begin
      check_eq("hold_pc_en", 32'(PcEnable), 32'd1);
    end
  endtask

  // Advance one clock; the bench's PC register loads on PcEnable=0.
  task automatic advance();
    logic        pe;
    logic [31:0] po;
    pe = PcEnable;
    po = PcOut;
    @(posedge Clk);
    #1;
    if (!pe) PcIn = po;
    MemAck  = 1'b0;
    MemData = '0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      respond();
      advance();
    end
  endtask

  initial begin
    Reset = 1'b0; PcIn = '0; MemAck = 1'b0; MemData = '0; Stall = 1'b0;
    BranchTaken = 1'b0; BranchTarget = '0;
    lat = 0; wcnt = 0; dropping = 1'b0; force_ack = 1'b0; nxt_pc = '0; pulses = 0;

    // Reset values
    advance();
    advance();
    #2;
    check_eq("rst_mem_req", 32'(MemReq), 32'd0);
    check_eq("rst_mem_addr", MemAddr, 32'd0);
    check_eq("rst_valid", 32'(InstrValid), 32'd0);
    check_eq("rst_instr", Instr, 32'd0);
    check_eq("rst_instr_pc", InstrPc, 32'd0);
    check_eq("rst_pc_en", 32'(PcEnable), 32'd1);
    check_eq("rst_pc_out", PcOut, 32'd0);
    @(posedge Clk);
    #1;

    // Release: IDLE first, then a zero-wait stream from PC 0
    Reset = 1'b1;
    respond();
    check_eq("idle_no_req", 32'(MemReq), 32'd0);
    advance();
    run(8);

    // Wait states: ack three cycles after the request rises
    lat = 3;
    for (int i = 0; i < 4; i++) begin
      respond();
      if (!PcEnable) pulses++;
      advance();
    end
    check_eq("wait_pulses", 32'(pulses), 32'd1);
    run(4);

    // Stall with a valid output while another ack arrives: skid fills
    lat = 0;
    run(2);
    Stall = 1'b1;
    respond();
    advance();
    for (int i = 0; i < 3; i++) begin
      respond();
      check_eq("skid_no_req", 32'(MemReq), 32'd0);
      check_eq("skid_hold_vld", 32'(InstrValid), 32'd1);
      advance();
    end
    Stall = 1'b0;
    respond();
    advance();
    respond();
    check_eq("skid_back_to_back", 32'(InstrValid), 32'd1);
    advance();
    run(3);

    // Redirect two cycles into an outstanding request
    lat = 5;
    run(2);
    hold_addr    = nxt_pc;
    BranchTarget = 32'h100;
    BranchTaken  = 1'b1;
    respond();
    advance();
    BranchTaken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      respond();
      check_eq("drop_addr_hold", MemAddr, hold_addr);
      check_eq("drop_req_hold", 32'(MemReq), 32'd1);
      check_eq("drop_no_valid", 32'(InstrValid), 32'd0);
      advance();
    end
    lat = 0;
    respond();
    check_eq("redir_addr", MemAddr, 32'h100);
    advance();
    run(4);

    // PC wrap at the top of the address space
    BranchTarget = 32'hFFFF_FFFC;
    BranchTaken  = 1'b1;
    respond();
    advance();
    BranchTaken = 1'b0;
    respond();
    check_eq("wrap_addr", MemAddr, 32'hFFFF_FFFC);
    check_eq("wrap_pc_out", PcOut, 32'd0);
    advance();
    run(4);

    // Reset mid-request, then a late ack that must be ignored
    lat = 20;
    run(2);
    Reset = 1'b0;
    respond();
    check_eq("rstm_pc_en", 32'(PcEnable), 32'd1);
    check_eq("rstm_pc_out", PcOut, 32'd0);
    advance();
    Reset = 1'b1;
    sb.delete();
    wcnt     = 0;
    dropping = 1'b0;
    nxt_pc   = PcIn;
    #1;
    check_eq("rstm_mem_req", 32'(MemReq), 32'd0);
    check_eq("rstm_mem_addr", MemAddr, 32'd0);
    check_eq("rstm_valid", 32'(InstrValid), 32'd0);
    check_eq("rstm_instr", Instr, 32'd0);
    check_eq("rstm_instr_pc", InstrPc, 32'd0);
    force_ack = 1'b1;
    respond();
    advance();
    force_ack = 1'b0;
    lat = 0;
    respond();
    check_eq("late_ack_ignored", 32'(InstrValid), 32'd0);
    advance();
    run(6);

    #1;
    check_eq("sb_level", 32'(sb.size()), 32'(InstrValid));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
